vector_regfile_sb: RTL and testbench

VECTOR_REGFILE_SB -- requirements
Module: vector_regfile_sb

---
 rtl/vec_pkg.sv | 13 +
 rtl/vec_lane_merge.sv | 24 ++
 rtl/vector_regfile_sb.sv | 147 ++++++++++++++
 tb/tb_vector_regfile_sb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared defaults and FSM encoding for the vector register file.
package vec_pkg;

  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_LANE_W = 8;
  localparam int unsigned DEF_DEPTH  = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/vec_lane_merge.sv
// Per-lane merge: lanes selected by mask come from new_data, the rest from old_data.
module vec_lane_merge
  import vec_pkg::*;
#(
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned LANE_W = DEF_LANE_W
) (
  input  logic [LANES*LANE_W-1:0] old_data,
  input  logic [LANES*LANE_W-1:0] new_data,
  input  logic [LANES-1:0]        mask,
  output logic [LANES*LANE_W-1:0] merged
);

  // Lane-wise select between the old and new vector.
  always_comb begin
    merged = old_data;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        merged[i*LANE_W +: LANE_W] = new_data[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/vector_regfile_sb.sv
// Vector register file with per-lane write mask, write-to-read bypass,
// two read ports and a one-bit-per-register busy scoreboard.
module vector_regfile_sb
  import vec_pkg::*;
#(
  parameter  int unsigned LANES  = DEF_LANES,
  parameter  int unsigned LANE_W = DEF_LANE_W,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned VW     = LANES * LANE_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_a_addr,
  input  logic [AW-1:0]    rd_b_addr,
  output logic [VW-1:0]    rd_a_data,
  output logic [VW-1:0]    rd_b_data,
  output logic             rd_valid,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [LANES-1:0] wr_mask,
  input  logic [VW-1:0]    wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_err
);

  state_t           state;
  state_t           state_nxt;
  logic             sweep_en;
  logic [AW-1:0]    sweep_cnt;
  logic [VW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [VW-1:0]    old_wr, old_a, old_b;
  logic [VW-1:0]    wr_merged, byp_a, byp_b;
  logic             hit_a, hit_b, hit_rsv;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  // Next state: leave CLEAR once the last entry has been zeroed.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (sweep_cnt == AW'(DEPTH - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready    = (state == RUN);
    sweep_en = (state == CLEAR);
  end

  // Sweep counter, restarted from entry 0 by reset.
  always_ff @(posedge clk) begin
    if (rst)           sweep_cnt <= '0;
    else if (sweep_en) sweep_cnt <= sweep_cnt + 1'b1;
  end

  // Array reads and same-cycle write hit detection.
  always_comb begin
    old_wr  = mem[wr_addr];
    old_a   = mem[rd_a_addr];
    old_b   = mem[rd_b_addr];
    hit_a   = wr_en && (wr_addr == rd_a_addr);
    hit_b   = wr_en && (wr_addr == rd_b_addr);
    hit_rsv = wr_en && (wr_addr == rsv_addr);
  end

  vec_lane_merge #(.LANES(LANES), .LANE_W(LANE_W)) u_merge_wr (
    .old_data (old_wr),
    .new_data (wr_data),
    .mask     (wr_mask),
    .merged   (wr_merged)
  );

  // Each read port merges against its own old entry; only used on an address hit.
  vec_lane_merge #(.LANES(LANES), .LANE_W(LANE_W)) u_merge_a (
    .old_data (old_a),
    .new_data (wr_data),
    .mask     (wr_mask),
    .merged   (byp_a)
  );

  vec_lane_merge #(.LANES(LANES), .LANE_W(LANE_W)) u_merge_b (
    .old_data (old_b),
    .new_data (wr_data),
    .mask     (wr_mask),
    .merged   (byp_b)
  );

  // Storage: zeroed by the sweep, masked writes in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_en)   mem[sweep_cnt] <= '0;
      else if (wr_en) mem[wr_addr]   <= wr_merged;
    end
  end

  // Scoreboard update: write clears, then reservation sets (reservation wins).
  always_comb begin
    busy_nxt = busy;
    if (ready) begin
      if (wr_en)  busy_nxt[wr_addr]  = 1'b0;
      if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Registered read port outputs and reservation error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      rd_a_data <= '0;
      rd_b_data <= '0;
      busy_a    <= 1'b0;
      busy_b    <= 1'b0;
      rsv_err   <= 1'b0;
    end else begin
      rd_valid <= ready && rd_en;
      rsv_err  <= ready && rsv_en && busy[rsv_addr] && !hit_rsv;
      if (ready && rd_en) begin
        rd_a_data <= hit_a ? byp_a : old_a;
        rd_b_data <= hit_b ? byp_b : old_b;
        busy_a    <= busy[rd_a_addr] && !hit_a;
        busy_b    <= busy[rd_b_addr] && !hit_b;
      end
    end
  end

endmodule

// File: tb/tb_vector_regfile_sb.sv
// Randomized and directed bench for vector_regfile_sb against a behavioural model.
module tb_vector_regfile_sb;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 3;
  localparam int unsigned VW     = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready;
  logic             rd_en;
  logic [AW-1:0]    rd_a_addr, rd_b_addr;
  logic [VW-1:0]    rd_a_data, rd_b_data;
  logic             rd_valid, busy_a, busy_b;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [LANES-1:0] wr_mask;
  logic [VW-1:0]    wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             rsv_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [VW-1:0] mmem [DEPTH];
  bit            mbusy [DEPTH];
  bit            mrun;
  int            mcnt;
  logic [VW-1:0] ea, eb;
  bit            ev, eba, ebb, eerr, erst;

  always #5 clk = ~clk;

  vector_regfile_sb #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .rd_en     (rd_en),
    .rd_a_addr (rd_a_addr),
    .rd_b_addr (rd_b_addr),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .rd_valid  (rd_valid),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_mask   (wr_mask),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rsv_err   (rsv_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0; rsv_en = 0;
  endtask

  // Advance one clock: predict from the spec rules, then compare after the edge.
  task automatic tick();
    logic [VW-1:0] post;
    bit ha, hb;
    erst = rst;
    if (rst) begin
      mrun = 0; mcnt = 0;
      for (int i = 0; i < DEPTH; i++) mbusy[i] = 0;
      ev = 0; ea = '0; eb = '0; eba = 0; ebb = 0; eerr = 0;
    end else if (!mrun) begin
      mmem[mcnt] = '0;
      mcnt++;
      if (mcnt == DEPTH) mrun = 1;
      ev = 0; eerr = 0;
    end else begin
      post = mmem[wr_addr];
      for (int l = 0; l < LANES; l++)
        if (wr_mask[l]) post[l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
      ha = wr_en && (wr_addr == rd_a_addr);
      hb = wr_en && (wr_addr == rd_b_addr);
      ev = rd_en;
      if (rd_en) begin
        ea  = ha ? post : mmem[rd_a_addr];
        eb  = hb ? post : mmem[rd_b_addr];
        eba = mbusy[rd_a_addr] && !ha;
        ebb = mbusy[rd_b_addr] && !hb;
      end
      eerr = rsv_en && mbusy[rsv_addr] && !(wr_en && wr_addr == rsv_addr);
      if (wr_en) begin
        mmem[wr_addr]  = post;
        mbusy[wr_addr] = 0;
      end
      if (rsv_en) mbusy[rsv_addr] = 1;
    end
    @(posedge clk);
    #1;
    check("ready", 64'(ready), 64'(mrun));
    check("rd_valid", 64'(rd_valid), 64'(ev));
    check("rsv_err", 64'(rsv_err), 64'(eerr));
    check("rd_a_data", 64'(rd_a_data), 64'(ea));
    check("rd_b_data", 64'(rd_b_data), 64'(eb));
    if (ev || erst) begin
      check("busy_a", 64'(busy_a), 64'(eba));
      check("busy_b", 64'(busy_b), 64'(ebb));
    end
  endtask

  task automatic do_write(input int a, input logic [VW-1:0] d, input logic [LANES-1:0] m);
    idle();
    wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_mask = m;
    tick();
    idle();
  endtask

  task automatic do_read(input int a, input int b);
    idle();
    rd_en = 1; rd_a_addr = AW'(a); rd_b_addr = AW'(b);
    tick();
    idle();
  endtask

  task automatic reset_and_sweep(output int lat);
    rst = 1; tick(); tick();
    rst = 0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (ready) break;
    end
  endtask

  initial begin
    int lat;
    for (int i = 0; i < DEPTH; i++) begin mmem[i] = '0; mbusy[i] = 0; end
    mrun = 0; mcnt = 0;
    rst = 1; idle();
    rd_a_addr = '0; rd_b_addr = '0; wr_addr = '0; wr_mask = '0; wr_data = '0; rsv_addr = '0;

    // Reset and initial sweep.
    reset_and_sweep(lat);
    check("sweep_latency", 64'(lat), 64'd8);
    for (int i = 0; i < DEPTH; i++) begin
      do_read(i, DEPTH - 1 - i);
      check("zero_after_sweep", 64'(rd_a_data), 64'd0);
    end

    // Masked writes.
    do_write(1, 32'h01020304, 4'hF);
    do_write(1, 32'hAABBCCDD, 4'h5);
    do_read(1, 0);
    check("masked_merge", 64'(rd_a_data), 64'h01BB03DD);
    check("masked_valid", 64'(rd_valid), 64'd1);
    idle(); tick();
    check("valid_drops", 64'(rd_valid), 64'd0);
    check("data_holds", 64'(rd_a_data), 64'h01BB03DD);

    // Independent bypass on the two ports.
    do_write(2, 32'h05060708, 4'hF);
    do_write(3, 32'hCAFEF00D, 4'hF);
    idle();
    wr_en = 1; wr_addr = 2; wr_data = 32'h11223344; wr_mask = 4'h3;
    rd_en = 1; rd_a_addr = 2; rd_b_addr = 3;
    tick(); idle();
    check("bypass_a", 64'(rd_a_data), 64'h05063344);
    check("bypass_b_old", 64'(rd_b_data), 64'hCAFEF00D);

    // Scoreboard sequence.
    rsv_en = 1; rsv_addr = 4; tick(); idle();
    do_read(4, 0);
    check("busy_after_rsv", 64'(busy_a), 64'd1);
    rsv_en = 1; rsv_addr = 4; tick(); idle();
    check("rsv_err_pulse", 64'(rsv_err), 64'd1);
    tick();
    check("rsv_err_clear", 64'(rsv_err), 64'd0);
    wr_en = 1; wr_addr = 4; wr_data = 32'h0; wr_mask = 4'h0;
    rd_en = 1; rd_a_addr = 4; rd_b_addr = 4;
    tick(); idle();
    check("busy_wr_clear", 64'(busy_a), 64'd0);
    wr_en = 1; wr_addr = 5; wr_data = 32'h12345678; wr_mask = 4'hF;
    rsv_en = 1; rsv_addr = 5;
    tick(); idle();
    check("rsv_wr_no_err", 64'(rsv_err), 64'd0);
    do_read(5, 5);
    check("rsv_wins", 64'(busy_a), 64'd1);

    // Reset mid-sweep after data and busy bits were set.
    do_write(6, 32'hDEADBEEF, 4'hF);
    rsv_en = 1; rsv_addr = 6; tick(); idle();
    rst = 1; tick(); rst = 0;
    tick(); tick(); tick();
    reset_and_sweep(lat);
    check("resweep_latency", 64'(lat), 64'd8);
    for (int i = 0; i < DEPTH; i++) begin
      do_read(i, i);
      check("resweep_data", 64'(rd_a_data), 64'd0);
      check("resweep_busy", 64'(busy_a), 64'd0);
    end

    // Randomized traffic on a narrowed address set to force collisions.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      rd_en     = $urandom_range(0, 1);
      wr_en     = $urandom_range(0, 1);
      rsv_en    = $urandom_range(0, 2) == 0;
      rd_a_addr = AW'($urandom_range(0, 3));
      rd_b_addr = AW'($urandom_range(0, 7));
      wr_addr   = AW'($urandom_range(0, 3));
      rsv_addr  = AW'($urandom_range(0, 3));
      wr_mask   = LANES'($urandom);
      wr_data   = $urandom;
      tick();
    end
    rst = 0; idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
